// File: rtl/sparse_pos_encoder.sv
// Packs the nonzero coefficients of a dense ternary polynomial into
// {position, sign} entries, CORE_NUM per word, for the sparse multiplier's position memory.
//
// state  | meaning
// IDLE   | waiting for start
// ACCEPT | consuming coefficients, writing each filled word
// FLUSH  | final partial word (if any) is on the write port
// FIN    | done pulse, weight_err final
module sparse_pos_encoder #(
  parameter int POLY_LEN      = 512,
  parameter int CORE_NUM      = 4,
  parameter int SPARSE_NUM    = 256,
  parameter int POS_WIDTH     = $clog2(POLY_LEN),
  parameter int POS_MEM_DEPTH = (SPARSE_NUM + CORE_NUM - 1) / CORE_NUM,
  parameter int POS_MEM_WIDTH = (POS_WIDTH + 1) * CORE_NUM,
  parameter int ADDR_WIDTH    = (POS_MEM_DEPTH > 1) ? $clog2(POS_MEM_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     coeff_valid,
  output logic                     coeff_ready,
  input  logic [1:0]               coeff_in,
  output logic                     mem_pos_wren,
  output logic [ADDR_WIDTH-1:0]    mem_pos_wr_addr,
  output logic [POS_MEM_WIDTH-1:0] mem_pos_din,
  output logic                     busy,
  output logic                     done,
  output logic                     weight_err
);

  localparam int LANE_W = POS_WIDTH + 1;
  localparam int LIDX_W = $clog2(CORE_NUM + 1);
  localparam int CNT_W  = $clog2(POLY_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, FLUSH, FIN} state_t;

  state_t                   state_q, state_d;
  logic [POS_WIDTH-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]         nz_cnt_q, nz_cnt_d;
  logic [LIDX_W-1:0]        lane_idx_q, lane_idx_d;
  logic [ADDR_WIDTH-1:0]    word_addr_q, word_addr_d;
  logic [POS_MEM_WIDTH-1:0] lanes_q, lanes_d;
  logic                     weight_err_q, weight_err_d;
  logic                     wren_q, wren_d;
  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [POS_MEM_WIDTH-1:0] din_q, din_d;

  logic [POS_MEM_WIDTH-1:0] lanes_n;
  logic [LIDX_W-1:0]        lane_idx_n;
  logic [LANE_W-1:0]        entry;
  logic                     last;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    nz_cnt_d     = nz_cnt_q;
    lane_idx_d   = lane_idx_q;
    word_addr_d  = word_addr_q;
    lanes_d      = lanes_q;
    weight_err_d = weight_err_q;
    wren_d       = 1'b0;
    wr_addr_d    = '0;
    din_d        = '0;
    lanes_n      = lanes_q;
    lane_idx_n   = lane_idx_q;
    entry        = {idx_q, (coeff_in == 2'b01)};
    last         = (idx_q == POS_WIDTH'(POLY_LEN - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ACCEPT;
          idx_d        = '0;
          nz_cnt_d     = '0;
          lane_idx_d   = '0;
          word_addr_d  = '0;
          lanes_d      = '0;
          weight_err_d = 1'b0;
        end
      end
      ACCEPT: begin
        if (coeff_valid) begin
          idx_d = idx_q + POS_WIDTH'(1);
          if (coeff_in == 2'b10) begin
            weight_err_d = 1'b1;
          end else if (coeff_in[0]) begin
            nz_cnt_d = nz_cnt_q + CNT_W'(1);
            // Entries past SPARSE_NUM are counted but never stored.
            if (nz_cnt_q >= CNT_W'(SPARSE_NUM)) begin
              weight_err_d = 1'b1;
            end else begin
              for (int k = 0; k < CORE_NUM; k++) begin
                if (lane_idx_q == LIDX_W'(k)) lanes_n[k*LANE_W +: LANE_W] = entry;
              end
              lane_idx_n = lane_idx_q + LIDX_W'(1);
            end
          end
          // The final partial word is launched here so it lands in FLUSH.
          if ((lane_idx_n == LIDX_W'(CORE_NUM)) || (last && (lane_idx_n != '0))) begin
            wren_d      = 1'b1;
            din_d       = lanes_n;
            wr_addr_d   = word_addr_q;
            word_addr_d = word_addr_q + ADDR_WIDTH'(1);
            lanes_n     = '0;
            lane_idx_n  = '0;
          end
          lanes_d    = lanes_n;
          lane_idx_d = lane_idx_n;
          if (last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        weight_err_d = weight_err_q | (nz_cnt_q != CNT_W'(SPARSE_NUM));
        state_d      = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      nz_cnt_q     <= '0;
      lane_idx_q   <= '0;
      word_addr_q  <= '0;
      lanes_q      <= '0;
      weight_err_q <= 1'b0;
      wren_q       <= 1'b0;
      wr_addr_q    <= '0;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      nz_cnt_q     <= nz_cnt_d;
      lane_idx_q   <= lane_idx_d;
      word_addr_q  <= word_addr_d;
      lanes_q      <= lanes_d;
      weight_err_q <= weight_err_d;
      wren_q       <= wren_d;
      wr_addr_q    <= wr_addr_d;
      din_q        <= din_d;
    end
  end

  assign coeff_ready     = (state_q == ACCEPT);
  assign busy            = (state_q == ACCEPT) || (state_q == FLUSH);
  assign done            = (state_q == FIN);
  assign weight_err      = weight_err_q;
  assign mem_pos_wren    = wren_q;
  assign mem_pos_wr_addr = wr_addr_q;
  assign mem_pos_din     = din_q;

endmodule

// File: tb/tb_sparse_pos_encoder.sv
// Bench for sparse_pos_encoder: three instances (SPARSE_NUM 4, 5, 256) share one stimulus
// stream and are checked every cycle against a list-based model of the expected writes.
module tb_sparse_pos_encoder;
  localparam int PL = 512;
  localparam int CN = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic coeff_valid = 1'b0;
  logic [1:0] coeff_in = 2'b00;
  always #5 clk = ~clk;

  logic        ready [NI];
  logic        wren  [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic        werr  [NI];
  logic [5:0]  addr  [NI];
  logic [39:0] din   [NI];
  logic [0:0]  addr_a, addr_b;
  logic [5:0]  addr_c;
  assign addr[0] = {5'b0, addr_a};
  assign addr[1] = {5'b0, addr_b};
  assign addr[2] = addr_c;

  sparse_pos_encoder #(.SPARSE_NUM(4)) u_sp4 (
    .clk(clk), .rst(rst_n), .start(start), .coeff_valid(coeff_valid), .coeff_ready(ready[0]),
    .coeff_in(coeff_in), .mem_pos_wren(wren[0]), .mem_pos_wr_addr(addr_a), .mem_pos_din(din[0]),
    .busy(busy[0]), .done(done[0]), .weight_err(werr[0]));
  sparse_pos_encoder #(.SPARSE_NUM(5)) u_sp5 (
    .clk(clk), .rst(rst_n), .start(start), .coeff_valid(coeff_valid), .coeff_ready(ready[1]),
    .coeff_in(coeff_in), .mem_pos_wren(wren[1]), .mem_pos_wr_addr(addr_b), .mem_pos_din(din[1]),
    .busy(busy[1]), .done(done[1]), .weight_err(werr[1]));
  sparse_pos_encoder u_sp256 (
    .clk(clk), .rst(rst_n), .start(start), .coeff_valid(coeff_valid), .coeff_ready(ready[2]),
    .coeff_in(coeff_in), .mem_pos_wren(wren[2]), .mem_pos_wr_addr(addr_c), .mem_pos_din(din[2]),
    .busy(busy[2]), .done(done[2]), .weight_err(werr[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: written by the stimulus process, read by the compare process.
  logic [1:0]  cf  [PL];
  int          gap [PL];
  int          h   [PL];
  int          t_s = -100;
  int          last_h = -100;
  int          abort_cyc = -1;
  bit          test_open = 1'b0;
  logic [39:0] exp_din  [int];
  int          exp_addr [int];
  int          exp_nwr  [NI];
  bit          exp_werr [NI];

  typedef struct {int inst; int addr; logic [39:0] val;} pin_t;
  pin_t pins[$];
  int   pin_nwr  [NI];
  int   pin_werr [NI];

  int          n_checks = 0;
  int          n_err = 0;
  int          obs_nwr  [NI];
  int          obs_done [NI];
  bit          obs_werr [NI];
  logic [39:0] obs_img  [NI][64];

  function automatic int sp_of(int i);
    return (i == 0) ? 4 : ((i == 1) ? 5 : 256);
  endfunction

  function automatic void chk(string name, int inst, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc%0d: got %0h, want %0h", name, inst, cyc, act, exp);
    end
  endfunction

  // Expected writes from the coefficient list: keep the first SPARSE_NUM nonzeros, chunk by CN.
  task automatic build_model();
    exp_din.delete();
    exp_addr.delete();
    for (int i = 0; i < NI; i++) begin
      logic [9:0]  kq[$];
      int          kc[$];
      int          nz, sp, nw, wc;
      bit          bad;
      logic [39:0] w_din;
      nz = 0; bad = 1'b0; sp = sp_of(i);
      for (int p = 0; p < PL; p++) begin
        if (cf[p] == 2'b10) bad = 1'b1;
        else if (cf[p] != 2'b00) begin
          if (nz < sp) begin
            kq.push_back({p[8:0], (cf[p] == 2'b01)});
            kc.push_back(h[p]);
          end else bad = 1'b1;
          nz++;
        end
      end
      exp_werr[i] = bad || (nz != sp);
      nw = (kq.size() + CN - 1) / CN;
      exp_nwr[i] = nw;
      for (int w = 0; w < nw; w++) begin
        w_din = '0;
        for (int k = 0; k < CN; k++)
          if (w*CN + k < kq.size()) w_din[k*10 +: 10] = kq[w*CN + k];
        wc = (w*CN + CN - 1 < kq.size()) ? kc[w*CN + CN - 1] + 1 : last_h + 1;
        exp_din[wc*4 + i]  = w_din;
        exp_addr[wc*4 + i] = w;
      end
    end
  endtask

  always begin : cmp
    bit in_rst, ab, e_wren;
    int key;
    @(negedge clk);
    #1;
    in_rst = !rst_n;
    ab = (abort_cyc >= 0) && (cyc >= abort_cyc);
    if (start && !in_rst) begin
      for (int i = 0; i < NI; i++) begin
        obs_nwr[i] = 0; obs_done[i] = 0; obs_werr[i] = 1'b0;
        for (int a = 0; a < 64; a++) obs_img[i][a] = '0;
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (in_rst) begin
        chk("rst_ready", i, ready[i], 0);
        chk("rst_busy", i, busy[i], 0);
        chk("rst_done", i, done[i], 0);
        chk("rst_wren", i, wren[i], 0);
        chk("rst_werr", i, werr[i], 0);
        chk("rst_addr", i, addr[i], 0);
        chk("rst_din", i, din[i], 0);
      end else if (ab) begin
        chk("abort_ready", i, ready[i], 0);
        chk("abort_busy", i, busy[i], 0);
        chk("abort_done", i, done[i], 0);
        chk("abort_wren", i, wren[i], 0);
        chk("abort_werr", i, werr[i], 0);
      end else begin
        key = cyc*4 + i;
        e_wren = exp_din.exists(key);
        chk("coeff_ready", i, ready[i], (cyc > t_s) && (cyc <= last_h));
        chk("busy", i, busy[i], (cyc > t_s) && (cyc <= last_h + 1));
        chk("done", i, done[i], (cyc == last_h + 2));
        chk("wren", i, wren[i], e_wren);
        if (wren[i] && e_wren) begin
          chk("wr_addr", i, addr[i], exp_addr[key]);
          chk("wr_din", i, din[i], exp_din[key]);
        end
        if (done[i] && (cyc == last_h + 2)) chk("weight_err", i, werr[i], exp_werr[i]);
      end
      if (!in_rst) begin
        if (wren[i]) begin
          obs_nwr[i]++;
          obs_img[i][addr[i]] = din[i];
        end
        if (done[i]) begin
          obs_done[i]++;
          obs_werr[i] = werr[i];
        end
      end
    end
    if (!in_rst && !ab && test_open && (cyc == last_h + 3)) begin
      for (int i = 0; i < NI; i++) begin
        chk("n_writes", i, obs_nwr[i], exp_nwr[i]);
        chk("n_done", i, obs_done[i], 1);
        if (pin_nwr[i] >= 0) chk("pin_n_writes", i, obs_nwr[i], pin_nwr[i]);
        if (pin_werr[i] >= 0) chk("pin_weight_err", i, obs_werr[i], pin_werr[i]);
      end
      foreach (pins[j]) chk("pin_word", pins[j].inst, obs_img[pins[j].inst][pins[j].addr], pins[j].val);
    end
  end

  task automatic clear_test();
    pins.delete();
    for (int i = 0; i < NI; i++) begin
      pin_nwr[i] = -1;
      pin_werr[i] = -1;
    end
    for (int p = 0; p < PL; p++) begin
      cf[p] = 2'b00;
      gap[p] = 0;
    end
  endtask

  task automatic add_pin(int inst, int a, logic [39:0] v);
    pin_t t;
    t.inst = inst; t.addr = a; t.val = v;
    pins.push_back(t);
  endtask

  task automatic random_gaps();
    for (int p = 0; p < PL; p++)
      gap[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endtask

  task automatic run(input int abort_after);
    int acc, s;
    @(negedge clk);
    s = cyc;
    acc = 0;
    for (int p = 0; p < PL; p++) begin
      acc += gap[p];
      h[p] = s + 1 + p + acc;
    end
    t_s = s;
    last_h = h[PL-1];
    abort_cyc = -1;
    build_model();
    test_open = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < PL; p++) begin
      repeat (gap[p]) begin
        coeff_valid = 1'b0;
        @(negedge clk);
      end
      if (p == abort_after) begin
        coeff_valid = 1'b0;
        rst_n = 1'b0;
        abort_cyc = cyc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_open = 1'b0;
        return;
      end
      coeff_valid = 1'b1;
      coeff_in = cf[p];
      @(negedge clk);
    end
    coeff_valid = 1'b0;
    coeff_in = 2'b00;
    repeat (6) @(negedge clk);
    test_open = 1'b0;
  endtask

  task automatic pattern_t1();
    cf[0] = 2'b01; cf[3] = 2'b11; cf[7] = 2'b01; cf[511] = 2'b11;
    add_pin(0, 0, {10'd1022, 10'd15, 10'd6, 10'd1});
    pin_nwr[0] = 1; pin_werr[0] = 0;
  endtask

  task automatic pattern_even_alt();
    for (int j = 0; j < 256; j++) cf[2*j] = (j % 2 == 0) ? 2'b01 : 2'b11;
    add_pin(2, 5, {10'd92, 10'd89, 10'd84, 10'd81});
    add_pin(2, 63, {10'd1020, 10'd1017, 10'd1012, 10'd1009});
    add_pin(0, 0, {10'd12, 10'd9, 10'd4, 10'd1});
    pin_nwr[2] = 64; pin_werr[2] = 0;
    pin_nwr[0] = 1; pin_werr[0] = 1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      pin_nwr[i] = -1;
      pin_werr[i] = -1;
    end
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    clear_test(); pattern_t1(); run(-1);

    clear_test();
    cf[1] = 2'b01; cf[2] = 2'b01; cf[4] = 2'b01; cf[8] = 2'b01; cf[16] = 2'b01;
    add_pin(1, 0, {10'd17, 10'd9, 10'd5, 10'd3});
    add_pin(1, 1, {30'd0, 10'd33});
    pin_nwr[1] = 2; pin_werr[1] = 0;
    run(-1);

    clear_test(); pattern_even_alt(); run(-1);

    clear_test();
    cf[10] = 2'b01; cf[20] = 2'b11; cf[30] = 2'b01;
    add_pin(0, 0, {10'd0, 10'd61, 10'd40, 10'd21});
    pin_nwr[0] = 1; pin_werr[0] = 1;
    run(-1);

    clear_test();
    for (int p = 5; p <= 10; p++) cf[p] = 2'b11;
    add_pin(0, 0, {10'd16, 10'd14, 10'd12, 10'd10});
    add_pin(1, 1, {30'd0, 10'd18});
    pin_nwr[0] = 1; pin_werr[0] = 1; pin_werr[1] = 1;
    run(-1);

    clear_test();
    for (int p = 0; p < PL; p++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cf[p] = (r < 40) ? 2'b00 : (r < 69) ? 2'b01 : (r < 98) ? 2'b11 : 2'b10;
    end
    random_gaps();
    run(-1);

    clear_test(); pattern_even_alt(); random_gaps(); run(-1);

    clear_test();
    for (int p = 0; p < PL; p++) cf[p] = 2'($urandom_range(0, 1) * (($urandom_range(0, 1) == 1) ? 1 : 3));
    random_gaps();
    run(100);

    clear_test(); pattern_t1(); random_gaps(); run(-1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sparse_pos_encoder.md
Name: sparse_pos_encoder

Overview:
- Converts a dense ternary polynomial into the packed position+sign word format used by the sparse polynomial multiplier's position memory.
- Coefficients in {-1,0,+1} stream in index order 0..POLY_LEN-1.
- Each nonzero coefficient becomes one {position, sign} entry. Entries are packed CORE_NUM per word, and each completed word is written through a memory write port that connects directly to the multiplier's mem_pos_wren / mem_pos_wr_addr / mem_pos_din.
- Sits between the ternary sampler and the multiplier.

Parameters:
- POLY_LEN, 512, number of coefficients per polynomial.
- CORE_NUM, 4, entries packed per memory word.
- SPARSE_NUM, 256, expected number of nonzero coefficients (Hamming weight).
- POS_WIDTH, $clog2(POLY_LEN), position field width.
- POS_MEM_DEPTH, (SPARSE_NUM+CORE_NUM-1)/CORE_NUM, number of words in the position memory.
- POS_MEM_WIDTH, (POS_WIDTH+1)*CORE_NUM, width of one packed word.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins encoding; ignored while busy.
- coeff_valid  in  1  coeff_in is valid this cycle.
- coeff_ready  out  1  encoder accepts a coefficient this cycle.
- coeff_in  in  2  2'b00 = 0, 2'b01 = +1, 2'b11 = -1, 2'b10 = illegal.
- mem_pos_wren  out  1  write strobe to the position memory.
- mem_pos_wr_addr  out  $clog2(POS_MEM_DEPTH)  word address.
- mem_pos_din  out  POS_MEM_WIDTH  packed word.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- weight_err  out  1  nonzero count differed from SPARSE_NUM, or an illegal code was seen; valid with done, held until the next start.

Behaviour:
- Reset (rst=0, asynchronous): all outputs and internal registers go to 0; state goes to IDLE.
- Entry format: lane k of a word occupies bits [(POS_WIDTH+1)*(k+1)-1 : (POS_WIDTH+1)*k].
  - Bits [POS_WIDTH:1] hold the position; bit 0 holds the sign (1 = +1, 0 = -1).
  - Entry e is stored in word e/CORE_NUM, lane e%CORE_NUM. Positions are therefore strictly ascending across lanes and words.
- States: IDLE, ACCEPT, FLUSH, FIN.
- IDLE:
  - start=1 moves to ACCEPT on the next cycle and clears the index counter, nonzero counter, lane index, word address, lane buffer and weight_err.
- ACCEPT:
  - coeff_ready=1.
  - Handshake: a coefficient is consumed on any cycle with coeff_valid & coeff_ready. Gaps in coeff_valid are allowed.
  - Each consumed coefficient increments the index counter.
  - On a nonzero code, the entry {index, sign} is loaded into lane[lane_idx], lane_idx increments and the nonzero counter increments.
  - Code 2'b10 is treated as zero and sets weight_err.
  - When the consumed nonzero fills lane CORE_NUM-1, the next cycle drives mem_pos_wren=1 with mem_pos_din = lane buffer and mem_pos_wr_addr = current word address. The word address then increments, and the lane buffer and lane_idx clear.
  - A new coefficient may be consumed in the same cycle as that write (no stall).
  - After coefficient POLY_LEN-1 is consumed, go to FLUSH (coeff_ready=0 from that point).
- Overflow: entries beyond SPARSE_NUM are dropped (no write past POS_MEM_DEPTH-1) and set weight_err.
- FLUSH:
  - If lane_idx > 0, issue one write of the partial word, with unused upper lanes all zeros.
  - Otherwise no write. Then go to FIN.
- FIN:
  - done=1 for one cycle; weight_err |= (nonzero count != SPARSE_NUM); busy=0; return to IDLE.
- Writes occur only in ACCEPT or FLUSH; mem_pos_wren is never high in IDLE or FIN.
- Latency: done is asserted 2 cycles after the handshake of the last coefficient when a partial word remains, and also 2 cycles when no partial word remains (FLUSH takes one cycle with or without a write).
- Reset mid-operation: encoding aborts immediately; no further writes are issued; state returns to IDLE.
- start while busy: ignored.

Test Plan:
- SPARSE_NUM=4; nonzeros +1@0, -1@3, +1@7, -1@511; rest zero, coeff_valid continuous.
  - Required: exactly one write, address 0.
  - Lane fields: lane0 = pos 0, sign 1; lane1 = pos 3, sign 0; lane2 = pos 7, sign 1; lane3 = pos 511, sign 0.
  - done 2 cycles after the last handshake; weight_err=0.
- SPARSE_NUM=5; nonzeros at 1, 2, 4, 8, 16, all +1.
  - Required: word 0 holds positions 1, 2, 4, 8.
  - Word 1 written during FLUSH with lane0 = {16,1} and lanes 1-3 = 0.
  - Exactly 2 writes; weight_err=0.
- Defaults; 256 nonzeros at even indices with alternating signs.
  - Required: 64 writes at addresses 0..63.
  - Word w lane k holds position 2*(4w+k), with sign 1 when k is even.
  - weight_err=0.
- SPARSE_NUM=4; 3 nonzeros.
  - Required: 1 partial write; done; weight_err=1.
- SPARSE_NUM=4; 6 nonzeros.
  - Required: only address 0 written; the extra entries are dropped; weight_err=1.
- Stimulus variants:
  - Random coeff_valid gaps: the memory image must match the continuous-valid run.
  - Assert rst=0 after 100 coefficients: all outputs drop to 0 immediately with no further writes; a subsequent start encodes correctly.
